// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares the single-ported data memory between fetch (read-only) and load/store
module memory_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_done,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_write,
    input  logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic [31:0] mem_in_addr,
    output logic [31:0] mem_in_data,
    output logic        mem_in_valid,
    input  logic        mem_in_ready,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready,
    input  logic        mem_addr_error,
    output logic        addr_error,
    output logic        timeout_error
);

    localparam int BW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_write;
    logic          lat_owner;  // 1 = load/store, 0 = fetch
    logic [BW-1:0] burst;
    logic [TW-1:0] to_cnt;

    logic grant_any;
    logic grant_data;
    logic ready_hit;
    logic timeout_hit;

    // Fetch is only forced ahead once data has used up its burst allowance.
    assign grant_any   = fetch_valid || data_valid;
    assign grant_data  = data_valid && (!fetch_valid || (burst != BURST_MAX));
    assign ready_hit   = lat_write ? mem_in_ready : mem_out_ready;
    assign timeout_hit = (to_cnt == TO_LAST);

    assign mem_in_addr   = lat_addr;
    assign mem_out_addr  = lat_addr;
    assign mem_in_data   = lat_wdata;
    assign mem_in_valid  = (state == ISSUE) && lat_write;
    assign mem_out_valid = (state == ISSUE) && !lat_write;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   if (ready_hit || timeout_hit) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_write     <= 1'b0;
            lat_owner     <= 1'b0;
            burst         <= '0;
            to_cnt        <= '0;
            fetch_data    <= '0;
            fetch_done    <= 1'b0;
            data_rdata    <= '0;
            data_done     <= 1'b0;
            addr_error    <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            addr_error <= addr_error | mem_addr_error;
            case (state)
                IDLE: begin
                    if (!fetch_valid) burst <= '0;
                    if (grant_any) begin
                        to_cnt <= '0;
                        if (grant_data) begin
                            lat_addr  <= data_addr;
                            lat_wdata <= data_wdata;
                            lat_write <= data_write;
                            lat_owner <= 1'b1;
                            // grant_data with fetch waiting implies burst < MAX, so this saturates
                            if (fetch_valid) burst <= burst + 1'b1;
                        end else begin
                            lat_addr  <= fetch_addr;
                            lat_write <= 1'b0;
                            lat_owner <= 1'b0;
                            burst     <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (ready_hit) begin
                        if (lat_owner) begin
                            data_done <= 1'b1;
                            if (!lat_write) data_rdata <= mem_out_data;
                        end else begin
                            fetch_done <= 1'b1;
                            fetch_data <= mem_out_data;
                        end
                    end else if (timeout_hit) begin
                        timeout_error <= 1'b1;
                        if (lat_owner) begin
                            data_done  <= 1'b1;
                            data_rdata <= '0;
                        end else begin
                            fetch_done <= 1'b1;
                            fetch_data <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
